// File: rtl/vce_palette_gen2.sv
// Video colour encoder: CPU-programmable CRAM, dot-clock divider, pixel index -> RGB map.
// Latency: RGB/HSYN_o/VSYN_o update 2 clk after the ck_en cycle that samples VD; D_out 1 clk after a read.
// Backpressure: none; the CPU bus is strobe-based and the pixel path free-runs on ck_en.
//
// Ports:
//   clk, reset_N             clock, async active-low reset
//   A, D_in, D_out           CPU register select, write data, registered read data
//   CS_n, RD_n, WR_n         CPU strobes (active-low, synchronous to clk)
//   VD, HSYN, VSYN, BLANK    VDC pixel index, sync and blank
//   ck_en                    dot-clock enable pulse
//   VIDEO_R/G/B              registered colour outputs
//   HSYN_o, VSYN_o           sync delayed to line up with RGB
module vce_palette_gen2 #(
    parameter int IDX_W = 9,
    parameter int CH_W  = 3,
    parameter int SUB_W = 4
) (
    input  logic             clk,
    input  logic             reset_N,
    input  logic [2:0]       A,
    input  logic [7:0]       D_in,
    output logic [7:0]       D_out,
    input  logic             CS_n,
    input  logic             RD_n,
    input  logic             WR_n,
    input  logic [IDX_W-1:0] VD,
    input  logic             HSYN,
    input  logic             VSYN,
    input  logic             BLANK,
    output logic             ck_en,
    output logic [CH_W-1:0]  VIDEO_R,
    output logic [CH_W-1:0]  VIDEO_G,
    output logic [CH_W-1:0]  VIDEO_B,
    output logic             HSYN_o,
    output logic             VSYN_o
);
    localparam int W     = 3 * CH_W;
    localparam int DEPTH = 2 ** IDX_W;

    logic [W-1:0] cram [DEPTH];

    logic [1:0]       mode_q, mode_d;
    logic             mono_q, mono_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [7:0]       lat_q, lat_d;
    logic             wr_prev_q, rd_prev_q;
    logic [7:0]       dout_q, dout_d;
    logic [1:0]       cnt_q, cnt_d;

    logic [IDX_W-1:0] vd_s1_q;
    logic             hs_s1_q, vs_s1_q, bl_s1_q;
    logic [W-1:0]     pix_s2_q;
    logic             hs_s2_q, vs_s2_q, bl_s2_q;
    logic [CH_W-1:0]  r_q, g_q, b_q, r_d, g_d, b_d;
    logic             hs_o_q, vs_o_q;

    logic             wr_evt, rd_evt, commit;
    logic [W-1:0]     cpu_word;
    logic [IDX_W-1:0] pix_idx;

    // wr_prev_q resets low so a strobe already low at reset release needs a fresh fall.
    assign wr_evt   = !CS_n && !WR_n && wr_prev_q;
    // Increment on the trailing edge of an A=5 read so D_out stays stable for the strobe.
    assign rd_evt   = !CS_n && RD_n && !rd_prev_q && (A == 3'd5);
    assign commit   = wr_evt && (A == 3'd5);
    assign cpu_word = cram[addr_q];
    assign pix_idx  = (vd_s1_q[SUB_W-1:0] == '0) ? '0 : vd_s1_q;
    assign ck_en    = reset_N && (cnt_q == 2'd0);

    always_comb begin
        mode_d = mode_q;
        mono_d = mono_q;
        addr_d = addr_q;
        lat_d  = lat_q;
        if (wr_evt) begin
            case (A)
                3'd0: begin
                    mode_d = D_in[1:0];
                    mono_d = D_in[7];
                end
                3'd2:    addr_d = (addr_q & ~IDX_W'(8'hFF)) | IDX_W'(D_in);
                3'd3:    addr_d = IDX_W'({D_in, addr_q[7:0]});
                3'd4:    lat_d  = D_in;
                3'd5:    addr_d = addr_q + IDX_W'(1);
                default: ;
            endcase
        end else if (rd_evt) begin
            addr_d = addr_q + IDX_W'(1);
        end
    end

    always_comb begin
        dout_d = 8'h00;
        if (!CS_n && !RD_n) begin
            case (A)
                3'd4:    dout_d = cpu_word[7:0];
                3'd5:    dout_d = 8'(16'(cpu_word) >> 8);
                default: dout_d = 8'h00;
            endcase
        end
    end

    // Reload value is taken from the mode at reload time, so a mode change never truncates a period.
    always_comb begin
        if (cnt_q == 2'd0) begin
            case (mode_q)
                2'd0:    cnt_d = 2'd3;
                2'd1:    cnt_d = 2'd2;
                default: cnt_d = 2'd1;
            endcase
        end else begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_comb begin
        g_d = pix_s2_q[W-1:2*CH_W];
        r_d = pix_s2_q[2*CH_W-1:CH_W];
        b_d = pix_s2_q[CH_W-1:0];
        if (bl_s2_q) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end else if (mono_q) begin
            r_d = pix_s2_q[W-1:2*CH_W];
            b_d = pix_s2_q[W-1:2*CH_W];
        end
    end

    // CRAM has no reset; reads in the same clk as a write see the old word.
    always_ff @(posedge clk) begin
        if (commit) begin
            cram[addr_q] <= W'({D_in, lat_q});
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            mode_q    <= '0;
            mono_q    <= 1'b0;
            addr_q    <= '0;
            lat_q     <= '0;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b1;
            dout_q    <= '0;
            cnt_q     <= '0;
            vd_s1_q   <= '0;
            hs_s1_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            bl_s1_q   <= 1'b0;
            pix_s2_q  <= '0;
            hs_s2_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            bl_s2_q   <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_o_q    <= 1'b0;
            vs_o_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            mono_q    <= mono_d;
            addr_q    <= addr_d;
            lat_q     <= lat_d;
            wr_prev_q <= WR_n;
            rd_prev_q <= RD_n;
            dout_q    <= dout_d;
            cnt_q     <= cnt_d;
            if (ck_en) begin
                vd_s1_q <= VD;
                hs_s1_q <= HSYN;
                vs_s1_q <= VSYN;
                bl_s1_q <= BLANK;
            end
            pix_s2_q  <= cram[pix_idx];
            hs_s2_q   <= hs_s1_q;
            vs_s2_q   <= vs_s1_q;
            bl_s2_q   <= bl_s1_q;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_o_q    <= hs_s2_q;
            vs_o_q    <= vs_s2_q;
        end
    end

    assign D_out   = dout_q;
    assign VIDEO_R = r_q;
    assign VIDEO_G = g_q;
    assign VIDEO_B = b_q;
    assign HSYN_o  = hs_o_q;
    assign VSYN_o  = vs_o_q;

endmodule

// File: tb/tb_vce_palette_gen2.sv
// Bench for vce_palette_gen2: default instance plus a CH_W=5/IDX_W=8 instance on a shared CPU bus.
// Latency: pixel results are compared 2 clk after the sampling ck_en cycle.
// Backpressure: none; CPU strobes are driven by tasks.
module tb_vce_palette_gen2;

    logic       clk = 1'b0;
    logic       reset_N;
    logic [2:0] A;
    logic [7:0] D_in;
    logic [7:0] D_out, D_out2;
    logic       CS_n, RD_n, WR_n;
    logic [8:0] VD;
    logic       HSYN, VSYN, BLANK;
    logic       ck_en, ck_en2;
    logic [2:0] vr, vg, vb;
    logic [4:0] vr2, vg2, vb2;
    logic       hs_o, vs_o, hs_o2, vs_o2;

    always #5 clk = ~clk;

    vce_palette_gen2 dut (
        .clk(clk), .reset_N(reset_N), .A(A), .D_in(D_in), .D_out(D_out),
        .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .VD(VD), .HSYN(HSYN), .VSYN(VSYN),
        .BLANK(BLANK), .ck_en(ck_en), .VIDEO_R(vr), .VIDEO_G(vg), .VIDEO_B(vb),
        .HSYN_o(hs_o), .VSYN_o(vs_o)
    );

    vce_palette_gen2 #(.IDX_W(8), .CH_W(5), .SUB_W(4)) dut2 (
        .clk(clk), .reset_N(reset_N), .A(A), .D_in(D_in), .D_out(D_out2),
        .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .VD(VD[7:0]), .HSYN(HSYN), .VSYN(VSYN),
        .BLANK(BLANK), .ck_en(ck_en2), .VIDEO_R(vr2), .VIDEO_G(vg2), .VIDEO_B(vb2),
        .HSYN_o(hs_o2), .VSYN_o(vs_o2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the default instance: palette contents and CPU registers.
    logic [8:0] cram_m [512];
    logic [8:0] addr_m;
    logic [7:0] lat_m, cr_m;
    int         written [$];

    typedef struct {
        logic [7:0] cr;
        logic [8:0] c21;
        logic [8:0] vd;
        logic       hs, vs, bl;
        logic [2:0] er, eg, eb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        A = a; D_in = d; CS_n = 1'b0; WR_n = 1'b0;
        @(posedge clk); #1;
        WR_n = 1'b1; CS_n = 1'b1;
        @(posedge clk);
        case (a)
            3'd0: cr_m = d;
            3'd2: addr_m = {addr_m[8], d};
            3'd3: addr_m = {d[0], addr_m[7:0]};
            3'd4: lat_m = d;
            3'd5: begin
                cram_m[addr_m] = 9'({d, lat_m});
                addr_m = 9'((int'(addr_m) + 1) % 512);
            end
            default: ;
        endcase
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        A = a; CS_n = 1'b0; RD_n = 1'b0;
        @(posedge clk); #1;
        d = D_out;
        RD_n = 1'b1;
        @(posedge clk); #1;
        CS_n = 1'b1;
        if (a == 3'd5) addr_m = 9'((int'(addr_m) + 1) % 512);
    endtask

    task automatic write_entry(input int idx, input logic [8:0] w);
        cpu_write(3'd2, 8'(idx % 256));
        cpu_write(3'd3, 8'(idx / 256));
        cpu_write(3'd4, w[7:0]);
        cpu_write(3'd5, {7'b0, w[8]});
    endtask

    task automatic model_rgb(input logic [8:0] vd, input logic bl,
                             output logic [2:0] r, output logic [2:0] g, output logic [2:0] b);
        int idx, w;
        idx = (int'(vd) % 16 == 0) ? 0 : int'(vd);
        w = int'(cram_m[idx]);
        b = 3'(w % 8);
        r = 3'((w / 8) % 8);
        g = 3'(w / 64);
        if (bl) begin
            r = 0; g = 0; b = 0;
        end else if (cr_m[7]) begin
            r = g; b = g;
        end
    endtask

    task automatic measure(output int per);
        int n = 0;
        while (ck_en !== 1'b1 && n < 16) begin
            @(posedge clk); #1; n++;
        end
        chk("ck_en_seen", 32'(ck_en), 32'd1);
        @(posedge clk); #1;
        per = 1;
        while (ck_en !== 1'b1 && per < 20) begin
            @(posedge clk); #1; per++;
        end
    endtask

    task automatic pix(input logic [8:0] vd, input logic hs, input logic vs, input logic bl,
                       input logic [2:0] er, input logic [2:0] eg, input logic [2:0] eb,
                       output logic [4:0] r2, output logic [4:0] g2, output logic [4:0] b2);
        int n = 0;
        @(posedge clk); #1;
        VD = vd; HSYN = hs; VSYN = vs; BLANK = bl;
        while (ck_en !== 1'b1 && n < 16) begin
            @(posedge clk); #1; n++;
        end
        chk("pix_ck_en", 32'(ck_en), 32'd1);
        @(posedge clk); #1;
        // Disturb the inputs after the sample edge: outputs must come from the sampled values.
        VD = 9'($urandom); HSYN = ~hs; VSYN = ~vs; BLANK = ~bl;
        @(posedge clk);
        @(posedge clk); #1;
        chk("R", 32'(vr), 32'(er));
        chk("G", 32'(vg), 32'(eg));
        chk("B", 32'(vb), 32'(eb));
        chk("HS", 32'(hs_o), 32'(hs));
        chk("VS", 32'(vs_o), 32'(vs));
        r2 = vr2; g2 = vg2; b2 = vb2;
        if (cr_m[1:0] == 2'd0) begin
            @(posedge clk); #1;
            chk("HOLD_RGB", 32'({vr, vg, vb}), 32'({er, eg, eb}));
            chk("HOLD_HS", 32'(hs_o), 32'(hs));
        end
    endtask

    initial begin
        vec_t       tbl [5];
        int         per;
        logic [7:0] d;
        logic [4:0] r2, g2, b2;
        logic [2:0] er, eg, eb;
        logic [8:0] vd;
        logic       hs, vs, bl;

        tbl[0] = '{cr: 8'h02, c21: 9'h1C0, vd: 9'h021, hs: 1'b1, vs: 1'b0, bl: 1'b0, er: 3'd0, eg: 3'd7, eb: 3'd0};
        tbl[1] = '{cr: 8'h02, c21: 9'h1C0, vd: 9'h120, hs: 1'b0, vs: 1'b1, bl: 1'b0, er: 3'd0, eg: 3'd0, eb: 3'd7};
        tbl[2] = '{cr: 8'h02, c21: 9'h1C0, vd: 9'h021, hs: 1'b1, vs: 1'b1, bl: 1'b1, er: 3'd0, eg: 3'd0, eb: 3'd0};
        tbl[3] = '{cr: 8'h80, c21: 9'h0F8, vd: 9'h021, hs: 1'b0, vs: 1'b0, bl: 1'b0, er: 3'd3, eg: 3'd3, eb: 3'd3};
        tbl[4] = '{cr: 8'h00, c21: 9'h0F8, vd: 9'h021, hs: 1'b1, vs: 1'b0, bl: 1'b0, er: 3'd7, eg: 3'd3, eb: 3'd0};

        reset_N = 1'b0; A = 3'd0; D_in = 8'h00; CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
        VD = 9'h000; HSYN = 1'b0; VSYN = 1'b0; BLANK = 1'b1;
        cr_m = 8'h00; addr_m = 9'h000; lat_m = 8'h00;
        for (int i = 0; i < 512; i++) cram_m[i] = 9'h000;

        // Reset state and divider.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ck_en", 32'(ck_en), 32'd0);
        chk("rst_dout", 32'(D_out), 32'd0);
        chk("rst_rgb", 32'({vr, vg, vb}), 32'd0);
        chk("rst_sync", 32'({hs_o, vs_o}), 32'd0);
        reset_N = 1'b1;
        #1;
        chk("first_ck_en", 32'(ck_en), 32'd1);
        measure(per);
        chk("period_mode0", 32'(per), 32'd4);
        chk("rgb_before_pixel", 32'({vr, vg, vb, hs_o, vs_o}), 32'd0);
        cpu_write(3'd0, 8'h01);
        measure(per);
        measure(per);
        chk("period_mode1", 32'(per), 32'd3);
        cpu_write(3'd0, 8'h02);
        measure(per);
        measure(per);
        chk("period_mode2", 32'(per), 32'd2);
        BLANK = 1'b0;

        // Write with auto-increment and wrap, then readback.
        write_entry(9'h1FF, 9'h138);
        cpu_write(3'd4, 8'h07);
        cpu_write(3'd5, 8'h00);
        cpu_write(3'd2, 8'hFF);
        cpu_write(3'd3, 8'h01);
        cpu_read(3'd4, d);
        chk("rd_lo_1FF", 32'(d), 32'h38);
        cpu_read(3'd5, d);
        chk("rd_hi_1FF", 32'(d), 32'h01);
        cpu_read(3'd4, d);
        chk("rd_lo_wrap0", 32'(d), 32'h07);
        cpu_read(3'd1, d);
        chk("rd_unmapped", 32'(d), 32'h00);

        // Table-driven pixel vectors.
        for (int i = 0; i < 5; i++) begin
            cpu_write(3'd0, tbl[i].cr);
            write_entry(9'h021, tbl[i].c21);
            pix(tbl[i].vd, tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].er, tbl[i].eg, tbl[i].eb, r2, g2, b2);
        end

        // Wide-channel instance: commit 0xFF / 0x7F, expect full-scale on all channels.
        cpu_write(3'd0, 8'h02);
        cpu_write(3'd2, 8'h11);
        cpu_write(3'd3, 8'h00);
        cpu_write(3'd4, 8'hFF);
        cpu_write(3'd5, 8'h7F);
        model_rgb(9'h011, 1'b0, er, eg, eb);
        pix(9'h011, 1'b0, 1'b0, 1'b0, er, eg, eb, r2, g2, b2);
        chk("w5_R", 32'(r2), 32'd31);
        chk("w5_G", 32'(g2), 32'd31);
        chk("w5_B", 32'(b2), 32'd31);

        // Randomized palette and pixels against the model.
        for (int i = 0; i < 20; i++) begin
            int idx;
            idx = int'($urandom_range(1, 511));
            write_entry(idx, 9'($urandom));
            written.push_back(idx);
        end
        for (int i = 0; i < 24; i++) begin
            if (i % 8 == 0) begin
                cpu_write(3'd0, {1'($urandom), 5'b0, 2'($urandom)});
            end
            if ($urandom_range(0, 3) == 0) vd = {5'($urandom), 4'b0};
            else vd = 9'(written[$urandom_range(0, written.size() - 1)]);
            hs = 1'($urandom); vs = 1'($urandom); bl = ($urandom_range(0, 3) == 0);
            model_rgb(vd, bl, er, eg, eb);
            pix(vd, hs, vs, bl, er, eg, eb, r2, g2, b2);
        end

        // Reset during a commit strobe; the strobe is still low at release and must not act.
        write_entry(0, 9'h0AA);
        @(posedge clk); #1;
        A = 3'd5; D_in = 8'h01; CS_n = 1'b0; WR_n = 1'b0;
        #1 reset_N = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_N = 1'b1;
        cr_m = 8'h00; addr_m = 9'h000; lat_m = 8'h00;
        repeat (3) @(posedge clk);
        #1 WR_n = 1'b1;
        @(posedge clk); #1 CS_n = 1'b1;
        cpu_read(3'd4, d);
        chk("rst_strobe_lo", 32'(d), 32'(cram_m[0][7:0]));
        cpu_read(3'd5, d);
        chk("rst_strobe_hi", 32'(d), 32'(cram_m[0][8]));
        cpu_read(3'd4, d);
        chk("rst_strobe_next", 32'(d), 32'(cram_m[1][7:0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
